fetch_unit: RTL and testbench

- IF stage of the 5-stage RISC-V pipeline: owns the PC register, drives a request/acknowledge instruction-memory port, and owns the IF/ID pipeline register.
- Sits directly upstream of the decode/control logic.
- Consumes the flush and PC-select outputs that decode/control derives from the branch-taken signal, plus a load-use stall from the hazard unit.
- Produces the instruction, PC and valid bit read by decode.

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the 5-stage RISC-V pipeline.
// Owns the PC, the req/ack instruction-memory port and the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        pc_mux_op_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_inst_o,
    output logic [31:0] if_id_pc_o,
    output logic        if_id_valid_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_KILL
    } state_t;

    typedef enum logic [1:0] {
        IF_KEEP,
        IF_BUBBLE,
        IF_MEM,
        IF_BUF
    } ifid_op_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic        r_req;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc;
    logic        r_ifid_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_nxt;
    logic        w_hold_ld;
    ifid_op_t    w_ifid_op;
    ifid_op_t    w_fill;
    logic        w_ack;
    logic        w_redir;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // An ack is only meaningful while a request is outstanding.
    assign w_ack    = imem_ack_i & r_req;
    assign w_redir  = pc_mux_op_i;
    assign w_target = branch_target_i & 32'hFFFF_FFFC;
    assign w_pc_inc = r_pc + 32'd4;

    // With nothing to deliver, IF/ID drains to a bubble unless stalled.
    assign w_fill = stall_i ? IF_KEEP : IF_BUBBLE;

    // Next-state, next-PC and IF/ID action decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_hold_ld   = 1'b0;
        w_ifid_op   = w_fill;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    if (w_redir) begin
                        w_pc_nxt = w_target;
                    end else if (stall_i) begin
                        w_hold_ld   = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_pc_nxt  = w_pc_inc;
                        w_ifid_op = IF_MEM;
                    end
                end else if (w_redir) begin
                    w_pend_nxt  = w_target;
                    w_state_nxt = S_KILL;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (!stall_i) begin
                    w_ifid_op   = IF_BUF;
                    w_state_nxt = S_REQ;
                end else begin
                    w_ifid_op = IF_KEEP;
                end
            end
            S_KILL: begin
                if (w_redir) begin
                    w_pend_nxt = w_target;
                end
                if (w_ack) begin
                    w_pc_nxt    = w_redir ? w_target : r_pend;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (flush_i) begin
            w_ifid_op = IF_BUBBLE;
        end
    end

    // Fetch FSM: state, PC, pending redirect, request strobe, hold buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_pend      <= 32'h0;
            r_req       <= 1'b0;
            r_hold_inst <= 32'h0;
            r_hold_pc   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_req   <= (w_state_nxt == S_REQ) || (w_state_nxt == S_KILL);
            if (w_hold_ld) begin
                r_hold_inst <= imem_rdata_i;
                r_hold_pc   <= r_pc;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ifid_inst  <= NOP_INST;
            r_ifid_pc    <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else begin
            unique case (w_ifid_op)
                IF_KEEP: begin
                    r_ifid_valid <= r_ifid_valid;
                end
                IF_BUBBLE: begin
                    r_ifid_inst  <= NOP_INST;
                    r_ifid_valid <= 1'b0;
                end
                IF_MEM: begin
                    r_ifid_inst  <= imem_rdata_i;
                    r_ifid_pc    <= r_pc;
                    r_ifid_valid <= 1'b1;
                end
                IF_BUF: begin
                    r_ifid_inst  <= r_hold_inst;
                    r_ifid_pc    <= r_hold_pc;
                    r_ifid_valid <= 1'b1;
                end
                default: begin
                    r_ifid_valid <= r_ifid_valid;
                end
            endcase
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign if_id_inst_o  = r_ifid_inst;
    assign if_id_pc_o    = r_ifid_pc;
    assign if_id_valid_o = r_ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based scoreboard
// checking every instruction that enters IF/ID.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        flush;
    logic        pcmux;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        ack_en;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        valid;
    logic [31:0] pco;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] q[$];

    assign ack   = req & ack_en;
    assign rdata = addr | 32'h13;

    fetch_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .stall_i        (stall),
        .flush_i        (flush),
        .pc_mux_op_i    (pcmux),
        .branch_target_i(target),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_ack_i     (ack),
        .imem_rdata_i   (rdata),
        .if_id_inst_o   (inst),
        .if_id_pc_o     (ipc),
        .if_id_valid_o  (valid),
        .pc_o           (pco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a);
        q.push_back({a | 32'h13, a});
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_req"}, {31'h0, req}, 32'h0);
        chk({nm, "_pc"}, pco, 32'h0);
        chk({nm, "_addr"}, addr, 32'h0);
        chk({nm, "_inst"}, inst, 32'h13);
        chk({nm, "_ifpc"}, ipc, 32'h0);
        chk({nm, "_valid"}, {31'h0, valid}, 32'h0);
    endtask

    // Monitor: any edge that was not stalled must show either the next
    // scoreboard entry or a NOP bubble.
    initial begin
        logic        s;
        logic [63:0] e;
        forever begin
            @(posedge clk);
            s = stall;
            #1;
            if (!s) begin
                n_vec++;
                if (valid) begin
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_valid: got %h@%h expected none",
                                 inst, ipc);
                    end else begin
                        e = q.pop_front();
                        if ({inst, ipc} !== e) begin
                            n_err++;
                            $display("FAIL ifid: got %h@%h expected %h@%h",
                                     inst, ipc, e[63:32], e[31:0]);
                        end
                    end
                end else if (inst !== 32'h13) begin
                    n_err++;
                    $display("FAIL bubble: got %h expected 00000013", inst);
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        pcmux  = 1'b0;
        target = 32'h0;
        ack_en = 1'b0;
        nx();
        chk_reset("reset");
        nx();
        rst = 1'b0;
        nx();
        start = 1'b1;
        nx();
        start = 1'b0;
        chk("start_req", {31'h0, req}, 32'h1);
        chk("addr0", addr, 32'h0);
        ack_en = 1'b1;
        push(32'h0);
        nx();
        ack_en = 1'b0;
        chk("wait_addr1", addr, 32'h4);
        nx();
        chk("wait_addr2", addr, 32'h4);
        chk("wait_bub2", {31'h0, valid}, 32'h0);
        nx();
        chk("wait_addr3", addr, 32'h4);
        chk("wait_bub3", inst, 32'h13);
        ack_en = 1'b1;
        push(32'h4);
        nx();
        chk("addr8", addr, 32'h8);
        stall = 1'b1;
        nx();
        chk("hold_req", {31'h0, req}, 32'h0);
        chk("hold_inst", inst, 32'h17);
        chk("hold_ifpc", ipc, 32'h4);
        chk("hold_valid", {31'h0, valid}, 32'h1);
        nx();
        chk("hold_req2", {31'h0, req}, 32'h0);
        chk("hold_inst2", inst, 32'h17);
        stall = 1'b0;
        push(32'h8);
        nx();
        chk("addrC", addr, 32'hC);
        chk("reqC", {31'h0, req}, 32'h1);
        push(32'hC);
        nx();
        chk("addr10", addr, 32'h10);
        ack_en = 1'b0;
        pcmux  = 1'b1;
        flush  = 1'b1;
        target = 32'h40;
        nx();
        pcmux = 1'b0;
        flush = 1'b0;
        chk("kill_req", {31'h0, req}, 32'h1);
        chk("kill_addr", addr, 32'h10);
        chk("kill_bub", {31'h0, valid}, 32'h0);
        nx();
        chk("kill_addr2", addr, 32'h10);
        ack_en = 1'b1;
        nx();
        chk("redir_addr", addr, 32'h40);
        for (int i = 0; i < 4; i++) begin
            push(32'h40 + 32'(i * 4));
            nx();
            if (i > 0) chk("run_valid", {31'h0, valid}, 32'h1);
        end
        chk("run_ifpc", ipc, 32'h4C);
        ack_en = 1'b0;
        stall  = 1'b1;
        flush  = 1'b1;
        nx();
        chk("fs_inst", inst, 32'h13);
        chk("fs_valid", {31'h0, valid}, 32'h0);
        chk("fs_addr", addr, 32'h50);
        stall  = 1'b0;
        ack_en = 1'b1;
        pcmux  = 1'b1;
        target = 32'hA3;
        nx();
        chk("align_addr", addr, 32'hA0);
        target = 32'hFFFF_FFFF;
        nx();
        pcmux = 1'b0;
        flush = 1'b0;
        chk("top_addr", addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        nx();
        chk("wrap_addr", addr, 32'h0);
        push(32'h0);
        nx();
        chk("post_wrap", addr, 32'h4);
        ack_en = 1'b0;
        pcmux  = 1'b1;
        target = 32'h100;
        nx();
        pcmux = 1'b0;
        chk("kill2_req", {31'h0, req}, 32'h1);
        chk("kill2_addr", addr, 32'h4);
        #3 rst = 1'b1;
        #1 chk_reset("rst_kill");
        nx();
        rst    = 1'b0;
        start  = 1'b1;
        ack_en = 1'b1;
        nx();
        start = 1'b0;
        chk("restart_addr", addr, 32'h0);
        push(32'h0);
        nx();
        chk("restart_addr4", addr, 32'h4);
        stall = 1'b1;
        nx();
        chk("hold2_req", {31'h0, req}, 32'h0);
        #3 rst = 1'b1;
        #1 chk_reset("rst_hold");
        nx();
        rst   = 1'b0;
        stall = 1'b0;
        start = 1'b1;
        nx();
        start = 1'b0;
        chk("restart2_addr", addr, 32'h0);
        push(32'h0);
        nx();
        ack_en = 1'b0;
        nx();
        nx();
        chk("sb_empty", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
